// File: rtl/bridge_req_buffer.sv
// Bridge request buffer: queues upstream bridge strobes in a small FIFO, replays
// them downstream one at a time, and returns read data sampled a fixed delay after issue.
module bridge_req_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned READ_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             up_addr,
  input  logic [DATA_WIDTH-1:0]   up_wr_data,
  input  logic                    up_wr,
  input  logic                    up_rd,
  output logic [DATA_WIDTH-1:0]   up_rd_data,
  output logic                    up_rd_valid,
  output logic [31:0]             dn_addr,
  output logic [DATA_WIDTH-1:0]   dn_wr_data,
  output logic                    dn_wr,
  output logic                    dn_rd,
  input  logic [DATA_WIDTH-1:0]   dn_rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    collision
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(READ_CYCLES) + 1;

  typedef struct packed {
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  is_wr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic   push_c;
  logic   pop_c;
  logic   full_c;
  logic   accept_c;
  entry_t head_c;

  // A full FIFO still accepts a push when the engine pops in the same cycle.
  always_comb begin
    push_c   = up_wr | up_rd;
    pop_c    = (state == IDLE) && (level != '0);
    full_c   = (level == LVL_W'(DEPTH));
    accept_c = push_c && (!full_c || pop_c);
    head_c   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= '{addr: up_addr, wr_data: up_wr_data, is_wr: up_wr};
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (accept_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)    rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept_c && !pop_c) begin
        level <= level + LVL_W'(1);
      end else if (!accept_c && pop_c) begin
        level <= level - LVL_W'(1);
      end
      if (push_c && !accept_c) overflow  <= 1'b1;
      if (up_wr && up_rd)      collision <= 1'b1;
    end
  end

  // Issue engine; dn_wr stays high through ISSUE, so it doubles as the entry type there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dn_addr     <= '0;
      dn_wr_data  <= '0;
      dn_wr       <= 1'b0;
      dn_rd       <= 1'b0;
      up_rd_data  <= '0;
      up_rd_valid <= 1'b0;
    end else begin
      dn_wr       <= 1'b0;
      dn_rd       <= 1'b0;
      up_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_c) begin
            dn_addr    <= head_c.addr;
            dn_wr_data <= head_c.wr_data;
            dn_wr      <= head_c.is_wr;
            dn_rd      <= !head_c.is_wr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (dn_wr) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(READ_CYCLES - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            up_rd_data  <= dn_rd_data;
            up_rd_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_req_buffer.sv
// Self-checking bench for bridge_req_buffer: directed scenarios plus randomized
// traffic compared every cycle against a timeline model of the request queue.
module tb_bridge_req_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RC    = 2;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   up_addr = '0;
  logic [DW-1:0] up_wr_data = '0;
  logic          up_wr = 1'b0;
  logic          up_rd = 1'b0;
  logic [DW-1:0] up_rd_data;
  logic          up_rd_valid;
  logic [31:0]   dn_addr;
  logic [DW-1:0] dn_wr_data;
  logic          dn_wr;
  logic          dn_rd;
  logic [DW-1:0] dn_rd_data = '0;
  logic [LW-1:0] level;
  logic          overflow;
  logic          collision;

  int errors = 0;
  int checks = 0;

  bridge_req_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_CYCLES(RC)) dut (
    .clk(clk), .reset(reset),
    .up_addr(up_addr), .up_wr_data(up_wr_data), .up_wr(up_wr), .up_rd(up_rd),
    .up_rd_data(up_rd_data), .up_rd_valid(up_rd_valid),
    .dn_addr(dn_addr), .dn_wr_data(dn_wr_data), .dn_wr(dn_wr), .dn_rd(dn_rd),
    .dn_rd_data(dn_rd_data), .level(level), .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a request queue plus the cycles at which issue, sample and return happen.
  typedef struct packed {
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic          is_wr;
  } ent_t;

  ent_t          q[$];
  int            cyc = 0;
  int            next_pop = 0;
  int            iss_cyc = -1;
  int            samp_cyc = -1;
  int            valid_cyc = -1;
  logic          iss_wr = 1'b0;
  logic [31:0]   m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rd_data = '0;
  logic          m_ovf = 1'b0;
  logic          m_col = 1'b0;

  always @(posedge clk or posedge reset) begin
    ent_t e;
    if (reset) begin
      q.delete();
      next_pop = 0; iss_cyc = -1; samp_cyc = -1; valid_cyc = -1;
      iss_wr = 1'b0; m_addr = '0; m_data = '0; m_rd_data = '0;
      m_ovf = 1'b0; m_col = 1'b0;
    end else begin
      if (cyc == samp_cyc) begin
        m_rd_data = dn_rd_data;
        valid_cyc = cyc + 1;
      end
      if (cyc >= next_pop && q.size() > 0) begin
        e = q.pop_front();
        m_addr = e.addr; m_data = e.data; iss_wr = e.is_wr;
        iss_cyc = cyc + 1;
        if (e.is_wr) begin
          next_pop = cyc + 2;
        end else begin
          samp_cyc = cyc + 1 + int'(RC);
          next_pop = cyc + 2 + int'(RC);
        end
      end
      if (up_wr || up_rd) begin
        if (up_wr && up_rd) m_col = 1'b1;
        if (q.size() < int'(DEPTH)) q.push_back('{addr: up_addr, data: up_wr_data, is_wr: up_wr});
        else m_ovf = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("dn_wr",       64'(dn_wr),       64'((cyc == iss_cyc) && iss_wr));
    chk("dn_rd",       64'(dn_rd),       64'((cyc == iss_cyc) && !iss_wr));
    chk("dn_addr",     64'(dn_addr),     64'(m_addr));
    chk("dn_wr_data",  64'(dn_wr_data),  64'(m_data));
    chk("up_rd_valid", 64'(up_rd_valid), 64'(cyc == valid_cyc));
    chk("up_rd_data",  64'(up_rd_data),  64'(m_rd_data));
    chk("level",       64'(level),       64'(q.size()));
    chk("overflow",    64'(overflow),    64'(m_ovf));
    chk("collision",   64'(collision),   64'(m_col));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    up_wr = 1'b0;
    up_rd = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int first_v;
    int second_v;
    int pulses;
    int peak;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_level",    64'(level),      64'(0));
    chk("reset_dn_wr",    64'(dn_wr),      64'(0));
    chk("reset_rd_data",  64'(up_rd_data), 64'(0));
    chk("reset_overflow", 64'(overflow),   64'(0));

    // Single write: downstream strobe two cycles after the upstream one.
    up_wr = 1'b1; up_addr = 32'h10; up_wr_data = 32'hA5A5_A5A5;
    tick(); up_wr = 1'b0;
    chk("w1_level", 64'(level), 64'(1));
    tick();
    chk("w1_dn_wr",   64'(dn_wr),      64'(1));
    chk("w1_dn_addr", 64'(dn_addr),    64'(32'h10));
    chk("w1_dn_data", 64'(dn_wr_data), 64'(32'hA5A5_A5A5));
    tick();
    chk("w1_dn_wr_off", 64'(dn_wr), 64'(0));
    chk("w1_level_end", 64'(level), 64'(0));
    idle(4);

    // Single read: return visible READ_CYCLES+1 cycles after dn_rd.
    dn_rd_data = 32'h1234; up_rd = 1'b1; up_addr = 32'h40;
    tick(); up_rd = 1'b0;
    tick();
    chk("r1_dn_rd", 64'(dn_rd), 64'(1));
    tick(); tick();
    chk("r1_valid_early", 64'(up_rd_valid), 64'(0));
    tick();
    chk("r1_valid", 64'(up_rd_valid), 64'(1));
    chk("r1_data",  64'(up_rd_data),  64'(32'h1234));
    tick();
    chk("r1_valid_late", 64'(up_rd_valid), 64'(0));
    idle(4);

    // Back-to-back reads of unchanged data each return.
    dn_rd_data = 32'h55; up_rd = 1'b1; up_addr = 32'h44;
    tick(); up_addr = 32'h48;
    tick(); up_rd = 1'b0;
    first_v = -1; second_v = -1; pulses = 0;
    for (int off = 2; off <= 12; off++) begin
      if (up_rd_valid) begin
        pulses++;
        chk("rr_data", 64'(up_rd_data), 64'(32'h55));
        if (first_v < 0) first_v = off;
        else second_v = off;
      end
      tick();
    end
    chk("rr_pulses", 64'(pulses),   64'(2));
    chk("rr_first",  64'(first_v),  64'(5));
    chk("rr_second", 64'(second_v), 64'(9));
    idle(3);

    // Burst of six writes: pops overlap so the FIFO never fills.
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      up_wr = 1'b1; up_addr = 32'h100 + 32'(i); up_wr_data = 32'hB000 + 32'(i);
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    up_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (int'(level) > peak) peak = int'(level);
      tick();
    end
    chk("burst_peak",     64'(peak),     64'(3));
    chk("burst_overflow", 64'(overflow), 64'(0));

    // Read followed by six writes: the last write meets a full FIFO during ISSUE.
    up_rd = 1'b1; up_addr = 32'h200;
    tick(); up_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      up_wr = 1'b1; up_addr = 32'h300 + 32'(i); up_wr_data = 32'hC000 + 32'(i);
      tick();
    end
    idle(20);
    chk("ovf_flag", 64'(overflow), 64'(1));

    // Simultaneous strobes: queued as a write and flagged.
    up_wr = 1'b1; up_rd = 1'b1; up_addr = 32'h20; up_wr_data = 32'h77;
    tick(); up_wr = 1'b0; up_rd = 1'b0;
    chk("col_flag", 64'(collision), 64'(1));
    tick();
    chk("col_dn_wr",   64'(dn_wr),      64'(1));
    chk("col_dn_rd",   64'(dn_rd),      64'(0));
    chk("col_dn_data", 64'(dn_wr_data), 64'(32'h77));
    idle(3);

    // Asynchronous reset while a read waits for its data.
    dn_rd_data = 32'hDEAD; up_rd = 1'b1; up_addr = 32'h24;
    tick(); up_rd = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("ar_valid",     64'(up_rd_valid), 64'(0));
    chk("ar_rd_data",   64'(up_rd_data),  64'(0));
    chk("ar_level",     64'(level),       64'(0));
    chk("ar_overflow",  64'(overflow),    64'(0));
    chk("ar_collision", 64'(collision),   64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ar_no_return", 64'(up_rd_valid), 64'(0));
      tick();
    end

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      up_wr      = (r < 25);
      up_rd      = (r >= 20 && r < 45);
      up_addr    = $urandom;
      up_wr_data = $urandom;
      dn_rd_data = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        up_wr = 1'b0; up_rd = 1'b0;
      end
      tick();
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
